// File: rtl/cc_start_pattern_detector.sv
// Serial start-pattern hunter: finds comienzo1/comienzo2 in the bit stream, reports which one matched,
// then deserializes the following payload and offers it under a valid/ack handshake.
module cc_start_pattern_detector #(
  parameter int STARTDET_PATWIDTH  = 8,
  parameter int STARTDET_DATAWIDTH = 8
) (
  input  logic                          CC_STARTDET_CLOCK_50,
  input  logic                          CC_STARTDET_RESET_InHigh,
  input  logic                          CC_STARTDET_bit_In,
  input  logic                          CC_STARTDET_bitValid_In,
  input  logic [STARTDET_PATWIDTH-1:0]  CC_STARTDET_comienzo1_InBUS,
  input  logic [STARTDET_PATWIDTH-1:0]  CC_STARTDET_comienzo2_InBUS,
  input  logic                          CC_STARTDET_ack_In,
  output logic                          CC_STARTDET_select_Out,
  output logic                          CC_STARTDET_match_Out,
  output logic [STARTDET_DATAWIDTH-1:0] CC_STARTDET_data_OutBUS,
  output logic                          CC_STARTDET_valid_Out,
  output logic                          CC_STARTDET_overrun_Out
);
  localparam int PW = STARTDET_PATWIDTH;
  localparam int DW = STARTDET_DATAWIDTH;
  localparam int FW = $clog2(PW + 1);
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {ST_HUNT, ST_CAPTURE, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   window_q, window_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [DW-1:0]   pay_q, pay_d;
  logic [CW-1:0]   pay_cnt_q, pay_cnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic            select_q, select_d;
  logic            match_q, match_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic [PW-1:0]   win_shift;
  logic [DW-1:0]   pay_shift;

  assign win_shift = {window_q[PW-2:0], CC_STARTDET_bit_In};
  assign pay_shift = {pay_q[DW-2:0], CC_STARTDET_bit_In};

  always_comb begin
    state_d   = state_q;
    window_d  = window_q;
    fill_d    = fill_q;
    pay_d     = pay_q;
    pay_cnt_d = pay_cnt_q;
    data_d    = data_q;
    select_d  = select_q;
    match_d   = 1'b0;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_HUNT: begin
        if (CC_STARTDET_bitValid_In) begin
          window_d = win_shift;
          fill_d   = (fill_q == FW'(PW)) ? fill_q : fill_q + 1'b1;
          // Compare only once the window holds a full pattern's worth of real bits.
          if (fill_d == FW'(PW)) begin
            if (win_shift == CC_STARTDET_comienzo1_InBUS) begin
              select_d = 1'b0;
              match_d  = 1'b1;
            end else if (win_shift == CC_STARTDET_comienzo2_InBUS) begin
              select_d = 1'b1;
              match_d  = 1'b1;
            end
          end
          if (match_d) begin
            state_d   = ST_CAPTURE;
            pay_cnt_d = '0;
          end
        end
      end
      ST_CAPTURE: begin
        if (CC_STARTDET_bitValid_In) begin
          pay_d     = pay_shift;
          pay_cnt_d = pay_cnt_q + 1'b1;
          if (pay_cnt_q == CW'(DW - 1)) begin
            data_d  = pay_shift;
            valid_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Bits arriving here are dropped, including one coinciding with the accepted ack.
        if (CC_STARTDET_bitValid_In) overrun_d = 1'b1;
        if (valid_q && CC_STARTDET_ack_In) begin
          valid_d  = 1'b0;
          state_d  = ST_HUNT;
          window_d = '0;
          fill_d   = '0;
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge CC_STARTDET_CLOCK_50) begin
    if (CC_STARTDET_RESET_InHigh) begin
      state_q   <= ST_HUNT;
      window_q  <= '0;
      fill_q    <= '0;
      pay_q     <= '0;
      pay_cnt_q <= '0;
      data_q    <= '0;
      select_q  <= 1'b0;
      match_q   <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      window_q  <= window_d;
      fill_q    <= fill_d;
      pay_q     <= pay_d;
      pay_cnt_q <= pay_cnt_d;
      data_q    <= data_d;
      select_q  <= select_d;
      match_q   <= match_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign CC_STARTDET_select_Out  = select_q;
  assign CC_STARTDET_match_Out   = match_q;
  assign CC_STARTDET_data_OutBUS = data_q;
  assign CC_STARTDET_valid_Out   = valid_q;
  assign CC_STARTDET_overrun_Out = overrun_q;
endmodule

// File: tb/tb_cc_start_pattern_detector.sv
// Directed bench for the start-pattern detector: hand-computed frames, match counting, handshake and reset.
module tb_cc_start_pattern_detector;
  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in, bit_vld, ack;
  logic [7:0] c1, c2;
  logic       sel, match, valid, overrun;
  logic [7:0] data;

  int checks   = 0;
  int failures = 0;
  int nm       = 0;

  cc_start_pattern_detector #(.STARTDET_PATWIDTH(8), .STARTDET_DATAWIDTH(8)) dut (
    .CC_STARTDET_CLOCK_50       (clk),
    .CC_STARTDET_RESET_InHigh   (rst),
    .CC_STARTDET_bit_In         (bit_in),
    .CC_STARTDET_bitValid_In    (bit_vld),
    .CC_STARTDET_comienzo1_InBUS(c1),
    .CC_STARTDET_comienzo2_InBUS(c2),
    .CC_STARTDET_ack_In         (ack),
    .CC_STARTDET_select_Out     (sel),
    .CC_STARTDET_match_Out      (match),
    .CC_STARTDET_data_OutBUS    (data),
    .CC_STARTDET_valid_Out      (valid),
    .CC_STARTDET_overrun_Out    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the bit consumed.
  task automatic send_bit(input logic b);
    bit_in  = b;
    bit_vld = 1'b1;
    @(negedge clk);
    bit_vld = 1'b0;
    if (match) nm++;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    rst = 1'b1; bit_in = 1'b0; bit_vld = 1'b0; ack = 1'b0;
    c1 = 8'hA5; c2 = 8'h3C;
    idle(2);
    chk("rst_outs", {sel, match, valid, overrun, data}, 12'h000);
    rst = 1'b0;
    idle(1);

    // 1: A5 then 5A, ack held high while idle must be ignored
    ack = 1'b1; idle(2); ack = 1'b0;
    chk("t1_ack_ignored", valid, 1'b0);
    pat = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(pat[i]);
    chk("t1_no_early_match", nm, 0);
    send_bit(pat[0]);
    chk("t1_match_pulse", match, 1'b1);
    chk("t1_select", sel, 1'b0);
    send_bit(1'b0);
    chk("t1_match_one_clk", match, 1'b0);
    pat = 8'h5A;
    for (int i = 6; i >= 1; i--) send_bit(pat[i]);
    chk("t1_not_valid_yet", valid, 1'b0);
    send_bit(pat[0]);
    chk("t1_valid", valid, 1'b1);
    chk("t1_data", data, 8'h5A);
    chk("t1_match_count", nm, 1);
    do_ack();
    chk("t1_ack_clears", valid, 1'b0);
    chk("t1_data_kept", data, 8'h5A);

    // 2: junk 110, then 3C, then F0
    nm = 0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    pat = 8'h3C;
    for (int i = 7; i >= 1; i--) send_bit(pat[i]);
    chk("t2_no_match_before_11", nm, 0);
    send_bit(pat[0]);
    chk("t2_match_bit11", match, 1'b1);
    chk("t2_select", sel, 1'b1);
    send_byte(8'hF0);
    chk("t2_data", {valid, data}, 9'h1F0);
    do_ack();

    // 3: identical patterns, pattern 1 wins
    c1 = 8'h81; c2 = 8'h81; nm = 0;
    send_byte(8'h81);
    chk("t3_select_prio", {match, sel}, 2'b10);
    send_byte(8'h00);
    chk("t3_data", {valid, sel, data}, 10'h200);
    do_ack();
    c1 = 8'hA5; c2 = 8'h3C;

    // 4: hold ack low, bits in DONE set overrun
    send_byte(8'hA5);
    send_byte(8'h66);
    chk("t4_no_overrun_yet", overrun, 1'b0);
    idle(10);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("t4_data_stable", {valid, data}, 9'h166);
    chk("t4_overrun", overrun, 1'b1);
    do_ack();
    chk("t4_ack", valid, 1'b0);
    chk("t4_overrun_sticky", overrun, 1'b1);

    // 5: payload equal to a start pattern is data, not a match
    nm = 0;
    send_byte(8'h3C);
    send_byte(8'hA5);
    chk("t5_data", {valid, sel, data}, 10'h3A5);
    chk("t5_single_match", nm, 1);
    do_ack();

    // 6: reset after 4 payload bits, then a clean frame
    send_byte(8'hA5);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    rst = 1'b1;
    idle(1);
    chk("t6_rst_outs", {sel, match, valid, overrun, data}, 12'h000);
    rst = 1'b0;
    idle(1);
    send_byte(8'hA5);
    send_byte(8'hC3);
    chk("t6_recapture", {valid, sel, data}, 10'h2C3);
    do_ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
